// File: rtl/exc_pkg.sv
// Shared types and constants for the exception request controller.
package exc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  localparam logic [1:0] SEL_MASK    = 2'd0;
  localparam logic [1:0] SEL_PENDING = 2'd1;
  localparam logic [1:0] SEL_STATUS  = 2'd2;
  localparam logic [1:0] SEL_EPC     = 2'd3;

  localparam int unsigned STATUS_IN_SERVICE_BIT = 0;
  localparam int unsigned STATUS_CAUSE_LSB      = 2;
  localparam int unsigned CAUSE_W               = 3;

  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_01a0;

endpackage

// File: rtl/irq_edge_detect.sv
// Registers the interrupt lines and flags rising edges one bit per line.
module irq_edge_detect #(
  parameter int unsigned NUM_IRQ = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [NUM_IRQ-1:0] rise
);

  logic [NUM_IRQ-1:0] irq_q;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= '0;
    else     irq_q <= irq;
  end

  assign rise = irq & ~irq_q;

endmodule

// File: rtl/exc_request_ctrl.sv
// Interrupt request controller: pending/mask registers, exception entry on an
// instruction boundary, and return to EPC on eret.
module exc_request_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned NUM_IRQ      = 6,
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inst_boundary,
  input  logic [31:0]        pc,
  input  logic               eret,
  input  logic               reg_we,
  input  logic [1:0]         reg_sel,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               exl_set,
  output logic               exl_clear,
  output logic [31:0]        epc_out,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               in_service
);

  state_t               state, state_next;
  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   mask, pending, pending_next, clr_bits, active;
  logic [CAUSE_W-1:0]   cause_code, cause_next, lowest;
  logic                 eligible;
  logic                 exl_set_next, exl_clear_next, redirect_next;
  logic [31:0]          redirect_pc_next, epc_next;
  logic                 unused_wdata;

  irq_edge_detect #(.NUM_IRQ(NUM_IRQ)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .irq  (irq),
    .rise (rise)
  );

  // W1C clears first, then new edges are OR'd in so a same-cycle edge survives
  assign clr_bits     = (reg_we && reg_sel == SEL_PENDING) ? reg_wdata[NUM_IRQ-1:0] : '0;
  assign pending_next = (pending & ~clr_bits) | rise;
  assign active       = pending & mask;
  assign eligible     = |active;
  assign unused_wdata = ^reg_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask    <= '0;
      pending <= '0;
    end else begin
      pending <= pending_next;
      if (reg_we && reg_sel == SEL_MASK) mask <= reg_wdata[NUM_IRQ-1:0];
    end
  end

  // Lowest set index wins: scan downward so the last hit is the smallest
  always_comb begin
    lowest = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) lowest = CAUSE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      exl_set     <= 1'b0;
      exl_clear   <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      epc_out     <= '0;
      cause_code  <= '0;
    end else begin
      state       <= state_next;
      exl_set     <= exl_set_next;
      exl_clear   <= exl_clear_next;
      redirect    <= redirect_next;
      redirect_pc <= redirect_pc_next;
      epc_out     <= epc_next;
      cause_code  <= cause_next;
    end
  end

  always_comb begin
    state_next       = state;
    exl_set_next     = 1'b0;
    exl_clear_next   = 1'b0;
    redirect_next    = 1'b0;
    redirect_pc_next = redirect_pc;
    epc_next         = epc_out;
    cause_next       = cause_code;
    case (state)
      IDLE: begin
        if (inst_boundary && eligible) begin
          state_next       = SERVICE;
          exl_set_next     = 1'b1;
          redirect_next    = 1'b1;
          redirect_pc_next = HANDLER_ADDR;
          epc_next         = pc;
          cause_next       = lowest;
        end
      end
      SERVICE: begin
        // No nesting: further interrupts wait in pending until eret
        if (eret) begin
          state_next       = IDLE;
          exl_clear_next   = 1'b1;
          redirect_next    = 1'b1;
          redirect_pc_next = epc_out;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_service = (state == SERVICE);

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      SEL_MASK:    reg_rdata = 32'(mask);
      SEL_PENDING: reg_rdata = 32'(pending);
      SEL_STATUS: begin
        reg_rdata[STATUS_CAUSE_LSB +: CAUSE_W] = cause_code;
        reg_rdata[STATUS_IN_SERVICE_BIT]       = in_service;
      end
      SEL_EPC:     reg_rdata = epc_out;
      default:     reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exc_request_ctrl.sv
// Directed self-checking bench for exc_request_ctrl.
module tb_exc_request_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq;
  logic        inst_boundary;
  logic [31:0] pc;
  logic        eret;
  logic        reg_we;
  logic [1:0]  reg_sel;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        exl_set, exl_clear, redirect, in_service;
  logic [31:0] epc_out, redirect_pc;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] rd;

  exc_request_ctrl #(.NUM_IRQ(6), .HANDLER_ADDR(32'h0000_01a0)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq           (irq),
    .inst_boundary (inst_boundary),
    .pc            (pc),
    .eret          (eret),
    .reg_we        (reg_we),
    .reg_sel       (reg_sel),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .exl_set       (exl_set),
    .exl_clear     (exl_clear),
    .epc_out       (epc_out),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .in_service    (in_service)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [1:0] sel, output logic [31:0] data);
    reg_sel = sel;
    #1;
    data = reg_rdata;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [31:0] data);
    reg_we = 1'b1; reg_sel = sel; reg_wdata = data;
    step();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (exl_set !== 1'b0) begin n_fail++; $display("FAIL reset_exl_set got=%b exp=0", exl_set); end
    n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
    n_cmp++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_in_service got=%b exp=0", in_service); end
    n_cmp++; if (epc_out !== 32'h0) begin n_fail++; $display("FAIL reset_epc got=%h exp=0", epc_out); end
    n_cmp++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    rst = 1'b0;
    read_reg(2'd0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_mask got=%h exp=0", rd); end
    read_reg(2'd1, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_pending got=%h exp=0", rd); end
  endtask

  task automatic test_entry();
    write_reg(2'd0, 32'h4);
    irq = 6'b000100;
    step();
    read_reg(2'd1, rd);
    n_cmp++; if (rd !== 32'h4) begin n_fail++; $display("FAIL entry_pending got=%h exp=4", rd); end
    n_cmp++; if (exl_set !== 1'b0) begin n_fail++; $display("FAIL entry_early_exl got=%b exp=0", exl_set); end
    inst_boundary = 1'b1; pc = 32'h40;
    step();
    inst_boundary = 1'b0;
    n_cmp++; if (exl_set !== 1'b1) begin n_fail++; $display("FAIL entry_exl_set got=%b exp=1", exl_set); end
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL entry_redirect got=%b exp=1", redirect); end
    n_cmp++; if (redirect_pc !== 32'h1a0) begin n_fail++; $display("FAIL entry_redirect_pc got=%h exp=1a0", redirect_pc); end
    n_cmp++; if (epc_out !== 32'h40) begin n_fail++; $display("FAIL entry_epc got=%h exp=40", epc_out); end
    n_cmp++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL entry_in_service got=%b exp=1", in_service); end
    read_reg(2'd2, rd);
    n_cmp++; if (rd !== 32'h9) begin n_fail++; $display("FAIL entry_status got=%h exp=9", rd); end
    step();
    n_cmp++; if (exl_set !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL entry_pulse_width got=%b%b exp=00", exl_set, redirect); end
    n_cmp++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL entry_hold got=%b exp=1", in_service); end
  endtask

  task automatic test_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
    n_cmp++; if (exl_clear !== 1'b1) begin n_fail++; $display("FAIL eret_exl_clear got=%b exp=1", exl_clear); end
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL eret_redirect got=%b exp=1", redirect); end
    n_cmp++; if (redirect_pc !== 32'h40) begin n_fail++; $display("FAIL eret_redirect_pc got=%h exp=40", redirect_pc); end
    n_cmp++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL eret_in_service got=%b exp=0", in_service); end
    n_cmp++; if (epc_out !== 32'h40) begin n_fail++; $display("FAIL eret_epc_hold got=%h exp=40", epc_out); end
    step();
    n_cmp++; if (exl_clear !== 1'b0) begin n_fail++; $display("FAIL eret_pulse_width got=%b exp=0", exl_clear); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    n_cmp++; if (exl_clear !== 1'b0 || redirect !== 1'b0 || exl_set !== 1'b0) begin n_fail++; $display("FAIL eret_idle got=%b%b%b exp=000", exl_clear, redirect, exl_set); end
    write_reg(2'd1, 32'h4);
    read_reg(2'd1, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL eret_w1c got=%h exp=0", rd); end
  endtask

  task automatic test_mask_gate();
    write_reg(2'd0, 32'h0);
    irq = 6'b000110;
    step();
    read_reg(2'd1, rd);
    n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL mask_pending got=%h exp=2", rd); end
    inst_boundary = 1'b1; pc = 32'h80;
    step();
    n_cmp++; if (exl_set !== 1'b0) begin n_fail++; $display("FAIL mask_blocked got=%b exp=0", exl_set); end
    write_reg(2'd0, 32'h2);
    n_cmp++; if (exl_set !== 1'b0) begin n_fail++; $display("FAIL mask_same_cycle got=%b exp=0", exl_set); end
    step();
    inst_boundary = 1'b0;
    n_cmp++; if (exl_set !== 1'b1) begin n_fail++; $display("FAIL mask_exl_set got=%b exp=1", exl_set); end
    n_cmp++; if (epc_out !== 32'h80) begin n_fail++; $display("FAIL mask_epc got=%h exp=80", epc_out); end
    read_reg(2'd2, rd);
    n_cmp++; if (rd !== 32'h5) begin n_fail++; $display("FAIL mask_status got=%h exp=5", rd); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    n_cmp++; if (redirect_pc !== 32'h80) begin n_fail++; $display("FAIL mask_return_pc got=%h exp=80", redirect_pc); end
    write_reg(2'd1, 32'h2);
  endtask

  task automatic test_priority();
    write_reg(2'd0, 32'hb);
    irq = 6'b000000;
    step();
    irq = 6'b001001;
    step();
    read_reg(2'd1, rd);
    n_cmp++; if (rd !== 32'h9) begin n_fail++; $display("FAIL prio_pending got=%h exp=9", rd); end
    inst_boundary = 1'b1; pc = 32'h100;
    step();
    inst_boundary = 1'b0;
    read_reg(2'd2, rd);
    n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL prio_cause got=%h exp=1", rd); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    write_reg(2'd1, 32'h1);
    read_reg(2'd1, rd);
    n_cmp++; if (rd !== 32'h8) begin n_fail++; $display("FAIL prio_w1c got=%h exp=8", rd); end
    write_reg(2'd1, 32'h8);
    read_reg(2'd3, rd);
    n_cmp++; if (rd !== 32'h100) begin n_fail++; $display("FAIL prio_epc_read got=%h exp=100", rd); end
  endtask

  task automatic test_set_wins();
    write_reg(2'd0, 32'h0);
    irq = 6'b001101;
    write_reg(2'd1, 32'h4);
    read_reg(2'd1, rd);
    n_cmp++; if (rd !== 32'h4) begin n_fail++; $display("FAIL set_wins got=%h exp=4", rd); end
    write_reg(2'd3, 32'hdead_beef);
    read_reg(2'd3, rd);
    n_cmp++; if (rd !== 32'h100) begin n_fail++; $display("FAIL epc_write_ignored got=%h exp=100", rd); end
  endtask

  task automatic test_back_to_back();
    write_reg(2'd0, 32'h4);
    inst_boundary = 1'b1; pc = 32'h200;
    step();
    n_cmp++; if (exl_set !== 1'b1) begin n_fail++; $display("FAIL b2b_first_entry got=%b exp=1", exl_set); end
    eret = 1'b1; pc = 32'h300;
    step();
    eret = 1'b0;
    n_cmp++; if (exl_clear !== 1'b1 || exl_set !== 1'b0) begin n_fail++; $display("FAIL b2b_return got=%b%b exp=10", exl_clear, exl_set); end
    step();
    inst_boundary = 1'b0;
    n_cmp++; if (exl_set !== 1'b1 || exl_clear !== 1'b0) begin n_fail++; $display("FAIL b2b_reentry got=%b%b exp=10", exl_set, exl_clear); end
    n_cmp++; if (epc_out !== 32'h300) begin n_fail++; $display("FAIL b2b_epc got=%h exp=300", epc_out); end
  endtask

  task automatic test_reset_in_service();
    n_cmp++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL rsvc_precond got=%b exp=1", in_service); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL rsvc_in_service got=%b exp=0", in_service); end
    n_cmp++; if (epc_out !== 32'h0) begin n_fail++; $display("FAIL rsvc_epc got=%h exp=0", epc_out); end
    n_cmp++; if (exl_clear !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL rsvc_pulses got=%b%b exp=00", exl_clear, redirect); end
    read_reg(2'd0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rsvc_mask got=%h exp=0", rd); end
  endtask

  initial begin
    rst = 1'b1; irq = '0; inst_boundary = 1'b0; pc = '0; eret = 1'b0;
    reg_we = 1'b0; reg_sel = 2'd0; reg_wdata = '0;
    #1;
    test_reset();
    test_entry();
    test_eret();
    test_mask_gate();
    test_priority();
    test_set_wins();
    test_back_to_back();
    test_reset_in_service();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
